// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulus counter family.
package counter_pkg;

    // Direction encoding for the up input
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Boundary behaviour selected by the SATURATE parameter
    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Clamp a parallel-load value into 0 .. modulus-1 so that q can never
    // reach an out-of-range state. Fixed at 32 bits so timer blocks of any
    // width up to 32 can share it.
    function automatic logic [31:0] clamp_load(input logic [31:0] din,
                                               input int unsigned modulus);
        if (din < modulus)
            return din;
        else
            return modulus - 1;
    endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of the up/down modulus counter.
interface updown_mod_counter_if #(
    parameter int unsigned WIDTH = 3
);
    logic             sclr;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    // Controller side: drives commands, observes count and flags
    modport master (
        output sclr, load, din, en, up,
        input  q, tc, ovf
    );

    // Counter side
    modport slave (
        input  sclr, load, din, en, up,
        output q, tc, ovf
    );
endinterface

// File: rtl/modcount_next.sv
// Next-count and boundary detection for one enabled step of the counter.
module modcount_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MODULUS  = 8,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    output logic [WIDTH-1:0] q_next,
    output logic             at_bound
);

    localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] step;

    // Step one count in the requested direction; work one bit wider so the
    // increment past 2^WIDTH-1 is visible to the compare before truncation.
    always_comb begin
        q_ext    = {1'b0, q};
        step     = q_ext;
        at_bound = 1'b0;
        if (up == DIR_UP) begin
            step     = q_ext + 1'b1;
            at_bound = (step > MAXV);
            if (at_bound)
                step = (SATURATE == MODE_SAT) ? q_ext : '0;
        end else begin
            at_bound = (q_ext == '0);
            if (at_bound)
                step = (SATURATE == MODE_SAT) ? q_ext : MAXV;
            else
                step = q_ext - 1'b1;
        end
        q_next = step[WIDTH-1:0];
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable modulus, parallel load, synchronous
// clear, wrap/saturate mode and terminal count for cascading.
// State changes on the falling edge of clk; clr is an asynchronous reset.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MODULUS  = 8,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic                 clk,
    input  logic                 clr,
    updown_mod_counter_if.slave  bus
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("updown_mod_counter: WIDTH must be at least 1");
        end
        if (MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_modulus
            $error("updown_mod_counter: MODULUS must lie in 2 .. 2**WIDTH");
        end
        if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
            $error("updown_mod_counter: SATURATE must be 0 or 1");
        end
    endgenerate

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] load_val;
    logic             ovf_r;
    logic             at_bound;
    logic             tc_c;

    modcount_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .q        (q_r),
        .up       (bus.up),
        .q_next   (q_next),
        .at_bound (at_bound)
    );

    // Out-of-range load values land on the top count
    always_comb begin
        load_val = WIDTH'(clamp_load(32'(bus.din), MODULUS));
    end

    // Count register and sticky overflow: sclr > load > en > hold
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            q_r   <= '0;
            ovf_r <= 1'b0;
        end else if (bus.sclr) begin
            q_r   <= '0;
            ovf_r <= 1'b0;
        end else if (bus.load) begin
            q_r   <= load_val;
        end else if (bus.en) begin
            q_r   <= q_next;
            if (at_bound)
                ovf_r <= 1'b1;
        end
    end

    // Terminal count: next enabled edge crosses a boundary, suppressed while
    // any clear or load would override the count on that edge
    always_comb begin
        tc_c = bus.en & at_bound & ~clr & ~bus.sclr & ~bus.load;
    end

    assign bus.q   = q_r;
    assign bus.ovf = ovf_r;
    assign bus.tc  = tc_c;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench for updown_mod_counter.
module tb_updown_mod_counter;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(3)) b8  ();
    updown_mod_counter_if #(.WIDTH(3)) b6w ();
    updown_mod_counter_if #(.WIDTH(3)) b6s ();
    updown_mod_counter_if #(.WIDTH(4)) bc0 ();
    updown_mod_counter_if #(.WIDTH(4)) bc1 ();

    updown_mod_counter u8 (.clk(clk), .clr(clr), .bus(b8));

    updown_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) u6w (
        .clk(clk), .clr(clr), .bus(b6w));

    updown_mod_counter #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) u6s (
        .clk(clk), .clr(clr), .bus(b6s));

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) uc0 (
        .clk(clk), .clr(clr), .bus(bc0));

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) uc1 (
        .clk(clk), .clr(clr), .bus(bc1));

    assign bc1.en = bc0.tc;

    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_slot();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #1;
        checks++;
        if (b8.q !== 3'd0 || b8.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: q=%0d ovf=%0d expected q=0 ovf=0", b8.q, b8.ovf);
        end
        for (int i = 0; i < 2; i++) begin
            sample_slot();
            checks++;
            if (b6w.q !== 3'd0 || b6s.q !== 3'd0 || bc0.q !== 4'd0 || bc1.q !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold: q6w=%0d q6s=%0d qc0=%0d qc1=%0d expected all 0",
                         b6w.q, b6s.q, bc0.q, bc1.q);
            end
        end
        drive_slot();
        clr = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [2:0] exp_q;
        b8.en = 1'b1;
        b8.up = 1'b1;
        #1;
        checks++;
        if (b8.tc !== 1'b0) begin
            errors++;
            $display("FAIL up_tc_start: tc=%0d expected 0", b8.tc);
        end
        for (int i = 1; i <= 10; i++) begin
            sample_slot();
            exp_q = 3'(i % 8);
            checks++;
            if (b8.q !== exp_q) begin
                errors++;
                $display("FAIL up_q step %0d: q=%0d expected %0d", i, b8.q, exp_q);
            end
            checks++;
            if (b8.tc !== (exp_q == 3'd7)) begin
                errors++;
                $display("FAIL up_tc step %0d: tc=%0d expected %0d", i, b8.tc, exp_q == 3'd7);
            end
            checks++;
            if (b8.ovf !== (i >= 8)) begin
                errors++;
                $display("FAIL up_ovf step %0d: ovf=%0d expected %0d", i, b8.ovf, i >= 8);
            end
        end
        drive_slot();
        b8.en = 1'b0;
        sample_slot();
        checks++;
        if (b8.q !== 3'd2) begin
            errors++;
            $display("FAIL up_hold: q=%0d expected 2", b8.q);
        end
    endtask

    task automatic test_down_mod6();
        logic [2:0] exp_q [7] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};
        drive_slot();
        b6w.en = 1'b1;
        b6w.up = 1'b0;
        #1;
        checks++;
        if (b6w.tc !== 1'b1) begin
            errors++;
            $display("FAIL down_tc_start: tc=%0d expected 1", b6w.tc);
        end
        for (int i = 0; i < 7; i++) begin
            sample_slot();
            checks++;
            if (b6w.q !== exp_q[i]) begin
                errors++;
                $display("FAIL down_q step %0d: q=%0d expected %0d", i, b6w.q, exp_q[i]);
            end
            checks++;
            if (b6w.tc !== (exp_q[i] == 3'd0) || b6w.ovf !== 1'b1) begin
                errors++;
                $display("FAIL down_flags step %0d: tc=%0d ovf=%0d expected tc=%0d ovf=1",
                         i, b6w.tc, b6w.ovf, exp_q[i] == 3'd0);
            end
        end
        drive_slot();
        b6w.en = 1'b0;
    endtask

    task automatic test_saturate();
        logic [2:0] exp_q [5] = '{3'd4, 3'd5, 3'd5, 3'd5, 3'd5};
        logic       exp_o [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        drive_slot();
        b6s.din  = 3'd3;
        b6s.load = 1'b1;
        sample_slot();
        checks++;
        if (b6s.q !== 3'd3 || b6s.ovf !== 1'b0) begin
            errors++;
            $display("FAIL sat_load: q=%0d ovf=%0d expected q=3 ovf=0", b6s.q, b6s.ovf);
        end
        drive_slot();
        b6s.load = 1'b0;
        b6s.en   = 1'b1;
        b6s.up   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_slot();
            checks++;
            if (b6s.q !== exp_q[i] || b6s.ovf !== exp_o[i]) begin
                errors++;
                $display("FAIL sat_up step %0d: q=%0d ovf=%0d expected q=%0d ovf=%0d",
                         i, b6s.q, b6s.ovf, exp_q[i], exp_o[i]);
            end
            checks++;
            if (b6s.tc !== (exp_q[i] == 3'd5)) begin
                errors++;
                $display("FAIL sat_tc step %0d: tc=%0d expected %0d", i, b6s.tc, exp_q[i] == 3'd5);
            end
        end
        drive_slot();
        b6s.up = 1'b0;
        #1;
        checks++;
        if (b6s.tc !== 1'b0) begin
            errors++;
            $display("FAIL sat_flip_tc: tc=%0d expected 0", b6s.tc);
        end
        sample_slot();
        checks++;
        if (b6s.q !== 3'd4 || b6s.ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_flip: q=%0d ovf=%0d expected q=4 ovf=1", b6s.q, b6s.ovf);
        end
        drive_slot();
        b6s.en = 1'b0;
    endtask

    task automatic test_load_priority();
        drive_slot();
        b6w.din  = 3'd7;
        b6w.load = 1'b1;
        b6w.en   = 1'b1;
        b6w.up   = 1'b1;
        #1;
        checks++;
        if (b6w.tc !== 1'b0) begin
            errors++;
            $display("FAIL load_tc_mask: tc=%0d expected 0", b6w.tc);
        end
        sample_slot();
        checks++;
        if (b6w.q !== 3'd5 || b6w.ovf !== 1'b1) begin
            errors++;
            $display("FAIL load_clamp: q=%0d ovf=%0d expected q=5 ovf=1", b6w.q, b6w.ovf);
        end
        drive_slot();
        b6w.din = 3'd2;
        sample_slot();
        checks++;
        if (b6w.q !== 3'd2) begin
            errors++;
            $display("FAIL load_over_en: q=%0d expected 2", b6w.q);
        end
        drive_slot();
        b6w.sclr = 1'b1;
        b6w.din  = 3'd4;
        sample_slot();
        checks++;
        if (b6w.q !== 3'd0 || b6w.ovf !== 1'b0) begin
            errors++;
            $display("FAIL sclr_over_load: q=%0d ovf=%0d expected q=0 ovf=0", b6w.q, b6w.ovf);
        end
        drive_slot();
        b6w.up = 1'b0;
        #1;
        checks++;
        if (b6w.tc !== 1'b0) begin
            errors++;
            $display("FAIL sclr_tc_mask: tc=%0d expected 0", b6w.tc);
        end
        b6w.sclr = 1'b0;
        b6w.load = 1'b0;
        #1;
        checks++;
        if (b6w.tc !== 1'b1) begin
            errors++;
            $display("FAIL tc_after_release: tc=%0d expected 1", b6w.tc);
        end
        b6w.en = 1'b0;
    endtask

    task automatic test_async_reset();
        drive_slot();
        b8.din  = 3'd4;
        b8.load = 1'b1;
        sample_slot();
        checks++;
        if (b8.q !== 3'd4 || b8.ovf !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_load: q=%0d ovf=%0d expected q=4 ovf=1", b8.q, b8.ovf);
        end
        b8.load = 1'b0;
        b8.en   = 1'b1;
        b8.up   = 1'b1;
        #2;
        clr = 1'b1;
        #1;
        checks++;
        if (b8.q !== 3'd0 || b8.ovf !== 1'b0 || b8.tc !== 1'b0) begin
            errors++;
            $display("FAIL async_clr: q=%0d ovf=%0d tc=%0d expected 0 0 0", b8.q, b8.ovf, b8.tc);
        end
        sample_slot();
        checks++;
        if (b8.q !== 3'd0) begin
            errors++;
            $display("FAIL clr_held: q=%0d expected 0", b8.q);
        end
        drive_slot();
        clr = 1'b0;
        sample_slot();
        checks++;
        if (b8.q !== 3'd1) begin
            errors++;
            $display("FAIL first_after_clr: q=%0d expected 1", b8.q);
        end
        drive_slot();
        b8.en = 1'b0;
    endtask

    task automatic test_cascade();
        logic [3:0] e0;
        logic [3:0] e1;
        drive_slot();
        bc0.en = 1'b1;
        bc0.up = 1'b1;
        bc1.up = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            sample_slot();
            e0 = 4'(i % 10);
            e1 = 4'((i / 10) % 10);
            checks++;
            if (bc0.q !== e0 || bc1.q !== e1) begin
                errors++;
                $display("FAIL cascade step %0d: q1q0=%0d%0d expected %0d%0d",
                         i, bc1.q, bc0.q, e1, e0);
            end
        end
        checks++;
        if (bc0.ovf !== 1'b1 || bc1.ovf !== 1'b1) begin
            errors++;
            $display("FAIL cascade_ovf: ovf0=%0d ovf1=%0d expected 1 1", bc0.ovf, bc1.ovf);
        end
        drive_slot();
        bc0.en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr    = 1'b1;
        b8.sclr  = 1'b0; b8.load  = 1'b0; b8.din  = '0; b8.en  = 1'b0; b8.up  = 1'b1;
        b6w.sclr = 1'b0; b6w.load = 1'b0; b6w.din = '0; b6w.en = 1'b0; b6w.up = 1'b1;
        b6s.sclr = 1'b0; b6s.load = 1'b0; b6s.din = '0; b6s.en = 1'b0; b6s.up = 1'b1;
        bc0.sclr = 1'b0; bc0.load = 1'b0; bc0.din = '0; bc0.en = 1'b0; bc0.up = 1'b1;
        bc1.sclr = 1'b0; bc1.load = 1'b0; bc1.din = '0; bc1.up = 1'b1;

        test_reset();
        test_up_wrap();
        test_down_mod6();
        test_saturate();
        test_load_priority();
        test_async_reset();
        test_cascade();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected run to complete");
        $fatal(1, "watchdog expired");
    end

endmodule
